// File: rtl/fib_if.sv
// Producer handshake between fib_consumer and a Fibonacci term source.
// The consumer requests with c_en; the producer answers with c_valid/c_data.
interface fib_if;
  logic        c_en;
  logic        c_valid;
  logic [15:0] c_data;

  modport master (output c_en, input c_valid, input c_data);
  modport slave  (input c_en, output c_valid, output c_data);
endinterface

// File: rtl/fib_consumer.sv
// Requests Fibonacci terms one at a time, checks each against a locally generated
// sequence, and reports mismatch/timeout status and counters for the run.
module fib_consumer #(
  parameter int unsigned COUNT   = 16,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic        clock_2,
  input  logic        reset,
  fib_if.master       bus,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        timeout,
  output logic [7:0]  term_count,
  output logic [7:0]  err_count,
  output logic [15:0] last_value
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int unsigned TLIM        = TIMEOUT - 1;
  localparam logic [7:0]  TIMER_LIMIT = TLIM[7:0];
  localparam logic [7:0]  COUNT_V     = COUNT[7:0];

  state_t      state_r, state_s;
  logic [7:0]  timer_r, timer_s;
  logic [7:0]  term_r, term_s, term_inc_s;
  logic [7:0]  errc_r, errc_s;
  logic        error_r, error_s;
  logic        tmo_r, tmo_s;
  logic [15:0] last_r, last_s;
  logic [15:0] exp_a_r, exp_a_s;
  logic [15:0] exp_b_r, exp_b_s;
  logic        c_en_r, busy_r, done_r;

  // Next-state and datapath update for every FSM state
  always_comb begin
    state_s    = state_r;
    timer_s    = timer_r;
    term_s     = term_r;
    term_inc_s = term_r + 8'd1;
    errc_s     = errc_r;
    error_s    = error_r;
    tmo_s      = tmo_r;
    last_s     = last_r;
    exp_a_s    = exp_a_r;
    exp_b_s    = exp_b_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_s = ST_REQ;
          timer_s = 8'd0;
          term_s  = 8'd0;
          errc_s  = 8'd0;
          error_s = 1'b0;
          tmo_s   = 1'b0;
          last_s  = 16'd0;
          exp_a_s = 16'd0;
          exp_b_s = 16'd1;
        end else begin
          state_s = state_r;
        end
      end
      ST_REQ: begin
        state_s = ST_WAIT;
        timer_s = 8'd0;
      end
      ST_WAIT: begin
        // a valid arriving on the final wait cycle still beats the timeout
        if (bus.c_valid) begin
          last_s  = bus.c_data;
          state_s = ST_CHECK;
        end else if (timer_r == TIMER_LIMIT) begin
          tmo_s   = 1'b1;
          state_s = ST_DONE;
        end else begin
          timer_s = timer_r + 8'd1;
        end
      end
      ST_CHECK: begin
        if (last_r != exp_a_r) begin
          error_s = 1'b1;
          if (errc_r != 8'hFF) begin
            errc_s = errc_r + 8'd1;
          end else begin
            errc_s = errc_r;
          end
        end else begin
          error_s = error_r;
        end
        exp_a_s = exp_b_r;
        exp_b_s = exp_a_r + exp_b_r;
        term_s  = term_inc_s;
        if (term_inc_s == COUNT_V) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_REQ;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and output registers; outputs decode the next state
  always_ff @(posedge clock_2) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      timer_r <= 8'd0;
      term_r  <= 8'd0;
      errc_r  <= 8'd0;
      error_r <= 1'b0;
      tmo_r   <= 1'b0;
      last_r  <= 16'd0;
      exp_a_r <= 16'd0;
      exp_b_r <= 16'd1;
      c_en_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      timer_r <= timer_s;
      term_r  <= term_s;
      errc_r  <= errc_s;
      error_r <= error_s;
      tmo_r   <= tmo_s;
      last_r  <= last_s;
      exp_a_r <= exp_a_s;
      exp_b_r <= exp_b_s;
      c_en_r  <= (state_s == ST_REQ);
      busy_r  <= (state_s == ST_REQ) || (state_s == ST_WAIT) || (state_s == ST_CHECK);
      done_r  <= (state_s == ST_DONE);
    end
  end

  assign bus.c_en   = c_en_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign error      = error_r;
  assign timeout    = tmo_r;
  assign term_count = term_r;
  assign err_count  = errc_r;
  assign last_value = last_r;

endmodule

// File: tb/tb_fib_consumer.sv
// Bench for fib_consumer: three parameterisations share one clock; a Fibonacci
// table plus counting model supplies every expected result.
module tb_fib_consumer;

  typedef struct {
    bit          done;
    int          term;
    int          errc;
    bit          error;
    bit          tmo;
    logic [15:0] last;
  } exp_t;

  typedef struct {
    int   sel;
    int   bad_idx;
    bit   silent;
    exp_t e;
  } vec_t;

  logic        clock_2 = 1'b0;
  logic        reset;
  logic        start;
  logic        c_valid;
  logic [15:0] c_data;
  int          sel;

  int checks = 0;
  int errors = 0;

  int cnt_of [3] = '{16, 30, 5};
  int tmo_of [3] = '{8, 8, 2};
  logic [15:0] fib [64];

  logic       start_w [3];
  logic       cen_w   [3];
  logic       busy_w  [3];
  logic       done_w  [3];
  logic       err_w   [3];
  logic       tmo_w   [3];
  logic [7:0] tc_w    [3];
  logic [7:0] ec_w    [3];
  logic [15:0] lv_w   [3];

  always #5 clock_2 = ~clock_2;

  fib_if if_a ();
  fib_if if_b ();
  fib_if if_c ();

  assign if_a.c_valid = c_valid;
  assign if_b.c_valid = c_valid;
  assign if_c.c_valid = c_valid;
  assign if_a.c_data  = c_data;
  assign if_b.c_data  = c_data;
  assign if_c.c_data  = c_data;
  assign cen_w[0] = if_a.c_en;
  assign cen_w[1] = if_b.c_en;
  assign cen_w[2] = if_c.c_en;
  assign start_w[0] = start && (sel == 0);
  assign start_w[1] = start && (sel == 1);
  assign start_w[2] = start && (sel == 2);

  fib_consumer #(.COUNT(16), .TIMEOUT(8)) u_a (
    .clock_2(clock_2), .reset(reset), .bus(if_a.master), .start(start_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .error(err_w[0]), .timeout(tmo_w[0]),
    .term_count(tc_w[0]), .err_count(ec_w[0]), .last_value(lv_w[0]));

  fib_consumer #(.COUNT(30), .TIMEOUT(8)) u_b (
    .clock_2(clock_2), .reset(reset), .bus(if_b.master), .start(start_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .error(err_w[1]), .timeout(tmo_w[1]),
    .term_count(tc_w[1]), .err_count(ec_w[1]), .last_value(lv_w[1]));

  fib_consumer #(.COUNT(5), .TIMEOUT(2)) u_c (
    .clock_2(clock_2), .reset(reset), .bus(if_c.master), .start(start_w[2]),
    .busy(busy_w[2]), .done(done_w[2]), .error(err_w[2]), .timeout(tmo_w[2]),
    .term_count(tc_w[2]), .err_count(ec_w[2]), .last_value(lv_w[2]));

  task automatic tick();
    @(posedge clock_2);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input int s);
    chk($sformatf("%s_cen", tag), 32'(cen_w[s]), 0);
    chk($sformatf("%s_busy", tag), 32'(busy_w[s]), 0);
    chk($sformatf("%s_done", tag), 32'(done_w[s]), 0);
    chk($sformatf("%s_error", tag), 32'(err_w[s]), 0);
    chk($sformatf("%s_timeout", tag), 32'(tmo_w[s]), 0);
    chk($sformatf("%s_term", tag), 32'(tc_w[s]), 0);
    chk($sformatf("%s_errc", tag), 32'(ec_w[s]), 0);
    chk($sformatf("%s_last", tag), 32'(lv_w[s]), 0);
  endtask

  // Wait for a request, let d cycles pass, then optionally present value v.
  task automatic serve(input int d, input logic [15:0] v, input bit drive, input bit noise,
                       output int w);
    w = -1;
    for (int i = 0; i <= 20; i++) begin
      if (cen_w[sel]) begin
        w = i;
        break;
      end
      tick();
    end
    if (w < 0) begin
      chk("cen_wait", 0, 1);
      return;
    end
    for (int j = 1; j <= d; j++) begin
      if (noise) start = 1'($urandom_range(0, 1));
      tick();
      if (j == 1) begin
        chk("cen_pulse", 32'(cen_w[sel]), 0);
        chk("busy_wait", 32'(busy_w[sel]), 1);
      end
    end
    start = 1'b0;
    if (drive) begin
      c_valid = 1'b1;
      c_data  = v;
      tick();
      c_valid = 1'b0;
      c_data  = 16'($urandom);
    end
  endtask

  // One complete run; the model derives the final status from what was sent.
  task automatic do_run(input int s, input int bad_idx, input bit silent, input bit rnd,
                        output exp_t e);
    int cnt, tmo, d, w;
    logic [15:0] v;
    cnt = cnt_of[s];
    tmo = tmo_of[s];
    sel = s;
    e = '{default: 0};
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t < cnt; t++) begin
      if (silent) d = tmo + 1;
      else if (rnd) d = ($urandom_range(0, 9) == 0) ? tmo + 1 : int'($urandom_range(1, tmo));
      else d = 2;
      v = fib[t];
      if (t == bad_idx) v = v + 16'd1;
      else if (rnd && $urandom_range(0, 3) == 0) v = v ^ 16'($urandom_range(1, 65535));
      serve(d, v, !silent, rnd, w);
      if (w < 0) break;
      if (t > 0) chk("cen_latency", 32'(w), 1);
      if (d > tmo) begin
        e.tmo = 1'b1;
        break;
      end
      e.last = v;
      e.term++;
      if (v != fib[t]) begin
        e.error = 1'b1;
        if (e.errc != 255) e.errc++;
      end
    end
    e.done = 1'b1;
    for (int i = 0; i < 20 && !done_w[sel]; i++) tick();
  endtask

  task automatic cmp_run(input string tag, input int s, input exp_t e);
    chk($sformatf("%s_done", tag), 32'(done_w[s]), 32'(e.done));
    chk($sformatf("%s_busy", tag), 32'(busy_w[s]), 0);
    chk($sformatf("%s_term", tag), 32'(tc_w[s]), 32'(e.term));
    chk($sformatf("%s_errc", tag), 32'(ec_w[s]), 32'(e.errc));
    chk($sformatf("%s_error", tag), 32'(err_w[s]), 32'(e.error));
    chk($sformatf("%s_timeout", tag), 32'(tmo_w[s]), 32'(e.tmo));
    chk($sformatf("%s_last", tag), 32'(lv_w[s]), 32'(e.last));
    // DONE must ignore stray producer data
    for (int i = 0; i < 3; i++) begin
      c_valid = 1'b1;
      c_data  = 16'($urandom);
      tick();
    end
    c_valid = 1'b0;
    chk($sformatf("%s_hold_done", tag), 32'(done_w[s]), 32'(e.done));
    chk($sformatf("%s_hold_term", tag), 32'(tc_w[s]), 32'(e.term));
    chk($sformatf("%s_hold_last", tag), 32'(lv_w[s]), 32'(e.last));
  endtask

  function automatic vec_t mk(input int s, input int bad, input bit silent, input int term,
                              input int errc, input bit tmo, input logic [15:0] last);
    vec_t r;
    r.sel = s;
    r.bad_idx = bad;
    r.silent = silent;
    r.e.done = 1'b1;
    r.e.term = term;
    r.e.errc = errc;
    r.e.error = (errc != 0);
    r.e.tmo = tmo;
    r.e.last = last;
    return r;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [6];
    exp_t e;
    int   w, pulses;

    fib[0] = 16'd0;
    fib[1] = 16'd1;
    for (int i = 2; i < 64; i++) fib[i] = fib[i-1] + fib[i-2];

    vecs[0] = mk(0, -1, 1'b0, 16, 0, 1'b0, 16'd610);
    vecs[1] = mk(0,  5, 1'b0, 16, 1, 1'b0, 16'd610);
    vecs[2] = mk(0, -1, 1'b1,  0, 0, 1'b1, 16'd0);
    vecs[3] = mk(1, -1, 1'b0, 30, 0, 1'b0, 16'd55477);
    vecs[4] = mk(2,  0, 1'b0,  5, 1, 1'b0, 16'd3);
    vecs[5] = mk(2, -1, 1'b1,  0, 0, 1'b1, 16'd0);

    // reset then quiet idle
    reset = 1'b0; start = 1'b0; c_valid = 1'b0; c_data = 16'd0; sel = 0;
    tick();
    tick();
    for (int s = 0; s < 3; s++) chk_idle($sformatf("reset%0d", s), s);
    reset = 1'b1;
    c_valid = 1'b1;
    c_data = 16'h00AA;
    tick(); tick(); tick();
    c_valid = 1'b0;
    for (int s = 0; s < 3; s++) chk_idle($sformatf("idle%0d", s), s);

    // table-driven runs
    for (int k = 0; k < 6; k++) begin
      do_run(vecs[k].sel, vecs[k].bad_idx, vecs[k].silent, 1'b0, e);
      cmp_run($sformatf("vec%0d", k), vecs[k].sel, vecs[k].e);
    end

    // exact timeout timing with a silent producer
    sel = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("tmo_cen_high", 32'(cen_w[0]), 1);
    tick();
    chk("tmo_cen_fall", 32'(cen_w[0]), 0);
    pulses = 0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (cen_w[0]) pulses++;
    end
    chk("tmo_done_early", 32'(done_w[0]), 0);
    tick();
    chk("tmo_done_on_time", 32'(done_w[0]), 1);
    chk("tmo_flag", 32'(tmo_w[0]), 1);
    chk("tmo_term", 32'(tc_w[0]), 0);
    chk("tmo_extra_cen", 32'(pulses), 0);

    // reset mid-run in WAIT of the third term, with start and c_valid also high
    sel = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    serve(2, fib[0] ^ 16'h0005, 1'b1, 1'b0, w);
    serve(2, fib[1], 1'b1, 1'b0, w);
    chk("mid_errc_before", 32'(ec_w[0]), 1);
    serve(1, 16'd0, 1'b0, 1'b0, w);
    reset = 1'b0;
    start = 1'b1;
    c_valid = 1'b1;
    c_data = 16'h1234;
    tick();
    reset = 1'b1;
    start = 1'b0;
    c_valid = 1'b0;
    chk_idle("midreset", 0);
    tick();
    chk("midreset_stay", 32'(busy_w[0]), 0);
    do_run(0, -1, 1'b0, 1'b0, e);
    cmp_run("restart", 0, e);

    // randomized runs against the model
    for (int r = 0; r < 10; r++) begin
      int s;
      s = (r % 3 == 1) ? 2 : 0;
      do_run(s, -1, 1'b0, 1'b1, e);
      cmp_run($sformatf("rnd%0d", r), s, e);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fib_consumer.md
FIB_CONSUMER -- requirements
Module: fib_consumer

Interface
REQ-001 Parameter COUNT, default 16, SHALL set the number of terms consumed per run (legal range 1..255).
REQ-002 Parameter TIMEOUT, default 8, SHALL set the maximum number of WAIT cycles per term (legal range 2..255).
REQ-003 clock_2  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; it SHALL be sampled on the clock_2 rising edge.
REQ-005 start  input  1  run request; it SHALL be honoured only in IDLE or DONE.
REQ-006 c_valid  input  1  producer data-valid, already synchronised into clock_2.
REQ-007 c_data  input  16  producer term, qualified by c_valid.
REQ-008 c_en  output  1  one-cycle request to the producer for the next term.
REQ-009 busy  output  1  SHALL be high in the REQ, WAIT and CHECK states.
REQ-010 done  output  1  SHALL be high while in DONE.
REQ-011 error  output  1  sticky flag: at least one mismatch occurred in the run.
REQ-012 timeout  output  1  sticky flag: the run ended on a timeout.
REQ-013 term_count  output  8  number of terms checked in the run.
REQ-014 err_count  output  8  number of mismatches; it SHALL saturate at 255.
REQ-015 last_value  output  16  most recent captured c_data.

Function
REQ-016 The FSM states SHALL be IDLE, REQ, WAIT, CHECK and DONE.
REQ-017 In IDLE or DONE, start=1 SHALL enter REQ and, on that edge, clear term_count, err_count, error, timeout, last_value and the timer, and set exp_a=0 and exp_b=1.
REQ-018 start SHALL be ignored in REQ, WAIT and CHECK.
REQ-019 In REQ, c_en SHALL be 1 for exactly one cycle; the next state SHALL be WAIT with the timer cleared; c_en SHALL be 0 in all other states.
REQ-020 In WAIT with c_valid=1, c_data SHALL be captured into last_value and the next state SHALL be CHECK.
REQ-021 In WAIT with c_valid=0, the timer SHALL increment; when the timer equals TIMEOUT-1, the FSM SHALL set timeout=1 and enter DONE.
REQ-022 If c_valid=1 on the same cycle the timer reaches its limit, c_valid SHALL win: the value is captured and no timeout occurs.
REQ-023 c_valid SHALL be ignored in IDLE, REQ, CHECK and DONE; no capture occurs and no counter changes.
REQ-024 In CHECK, if last_value != exp_a, then error SHALL be set to 1 and err_count SHALL increment with saturation at 255.
REQ-025 In CHECK, expected-value generation SHALL be independent of received data: exp_a<=exp_b and exp_b<=(exp_a+exp_b) mod 2^16.
REQ-026 In CHECK, term_count SHALL increment; if the new value equals COUNT, the next state SHALL be DONE, otherwise REQ.
REQ-027 Latency from a term's c_valid capture to the next c_en SHALL be 2 cycles (WAIT -> CHECK -> REQ).
REQ-028 DONE SHALL hold all outputs stable until start is asserted.

Reset
REQ-029 With reset=0 at a clock_2 edge, the FSM SHALL enter IDLE in any state, including mid-run.
REQ-030 On that edge, c_en, busy, done, error, timeout, term_count, err_count, last_value and the timer SHALL all be 0, with exp_a=0 and exp_b=1.
REQ-031 reset SHALL take priority over start and c_valid.

Verification
REQ-032 reset low for 2 cycles, then high -> all outputs 0 and state IDLE; start=0 keeps the block idle.
REQ-033 COUNT=16; a producer model returns the true sequence 2 cycles after each c_en -> done=1, term_count=16, err_count=0, error=0, last_value=610.
REQ-034 COUNT=16; the model returns 6 instead of 5 at term index 5 -> error=1, err_count=1, and all later terms pass, ending with last_value=610.
REQ-035 COUNT=16, TIMEOUT=8; the model never asserts c_valid -> c_en pulses once, timeout=1 and done=1 exactly 8 cycles after c_en falls, term_count=0.
REQ-036 COUNT=30; correct sequence -> term index 25 checks against 9489 (wrapped) with no error, ending with last_value=55477 and term_count=30.
REQ-037 reset asserted in WAIT during the third term -> next cycle is IDLE with all outputs 0; a subsequent start restarts the run from exp_a=0.
